// File: rtl/trans_conv_pass_scheduler.sv
// Pass sequencer for a shared transposed-conv datapath: for every (oc, ic) pair it
// clears the layer, loads kernel + bias from ROM, streams one input plane and waits for the output plane.
module trans_conv_pass_scheduler #(
   parameter int IN_WIDTH   = 7,
   parameter int DATA_WIDTH = 16,
   parameter int IN_CH      = 2,
   parameter int OUT_CH     = 2,
   parameter int PAD_TOP    = 1,
   parameter int PAD_BOTTOM = 2,
   parameter int PAD_LEFT   = 1,
   parameter int PAD_RIGHT  = 2,
   localparam int OUT_W   = 2*IN_WIDTH + PAD_LEFT + PAD_RIGHT - 3,
   localparam int OUT_H   = 2*IN_WIDTH + PAD_TOP + PAD_BOTTOM - 3,
   localparam int PIX_IN  = IN_WIDTH*IN_WIDTH,
   localparam int PIX_OUT = OUT_W*OUT_H,
   localparam int WA_W    = $clog2(OUT_CH*IN_CH*16 + OUT_CH),
   localparam int FA_W    = $clog2(IN_CH*PIX_IN),
   localparam int OC_W    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
   localparam int IC_W    = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     wrom_rd,
   output logic [WA_W-1:0]          wrom_addr,
   input  logic [DATA_WIDTH-1:0]    wrom_data,
   output logic                     fbuf_rd,
   output logic [FA_W-1:0]          fbuf_addr,
   input  logic [DATA_WIDTH-1:0]    fbuf_data,
   output logic                     layer_rst,
   output logic                     layer_valid,
   output logic [DATA_WIDTH-1:0]    layer_data,
   input  logic                     layer_ready,
   input  logic                     layer_valid_out,
   output logic [16*DATA_WIDTH-1:0] w_flat,
   output logic [DATA_WIDTH-1:0]    bias_out,
   output logic [OC_W-1:0]          oc_idx,
   output logic [IC_W-1:0]          ic_idx,
   output logic                     acc_first,
   output logic                     acc_last
);

   localparam int INC_W  = $clog2(PIX_IN + 1);
   localparam int OUTC_W = $clog2(PIX_OUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD_W, S_STREAM, S_DRAIN, S_NEXT
   } state_t;

   state_t                  r_state;
   logic [4:0]              r_cnt;
   logic [OC_W-1:0]         r_oc;
   logic [IC_W-1:0]         r_ic;
   logic [INC_W-1:0]        r_in_cnt;
   logic [OUTC_W-1:0]       r_out_cnt;
   logic                    r_fresh;
   logic                    r_held;
   logic                    r_done;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [DATA_WIDTH-1:0]   r_bias;
   logic [DATA_WIDTH-1:0]   r_w [16];

   logic                    w_lv;
   logic                    w_fbuf_rd;
   logic                    w_out_inc;
   logic                    w_last_pass;
   logic [DATA_WIDTH-1:0]   w_ldata;

   // ROM/buffer data arrives the cycle after the strobe, so a fresh word is passed straight
   // through and parked in r_data for as long as the datapath stalls.
   assign w_lv        = r_fresh || r_held;
   assign w_ldata     = r_fresh ? fbuf_data : r_data;
   assign w_fbuf_rd   = (r_state == S_STREAM) && (r_in_cnt < INC_W'(PIX_IN)) && (!w_lv || layer_ready);
   assign w_out_inc   = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && layer_valid_out &&
                        (r_out_cnt != OUTC_W'(PIX_OUT));
   assign w_last_pass = (r_oc == OC_W'(OUT_CH - 1)) && (r_ic == IC_W'(IN_CH - 1));

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign layer_rst   = (r_state == S_CLEAR);
   assign wrom_rd     = (r_state == S_LOAD_W) && (r_cnt <= 5'd16);
   assign fbuf_rd     = w_fbuf_rd;
   assign layer_valid = w_lv;
   assign layer_data  = w_ldata;
   assign bias_out    = r_bias;
   assign oc_idx      = r_oc;
   assign ic_idx      = r_ic;
   assign acc_first   = busy && (r_ic == '0);
   assign acc_last    = busy && (r_ic == IC_W'(IN_CH - 1));

   always_comb begin
      wrom_addr = '0;
      if (r_state == S_LOAD_W) begin
         if (r_cnt < 5'd16)
            wrom_addr = WA_W'((int'(r_oc)*IN_CH + int'(r_ic))*16 + int'(r_cnt));
         else
            wrom_addr = WA_W'(OUT_CH*IN_CH*16 + int'(r_oc));
      end
   end

   always_comb begin
      fbuf_addr = '0;
      if (r_state == S_STREAM)
         fbuf_addr = FA_W'(int'(r_ic)*PIX_IN + int'(r_in_cnt));
   end

   always_comb begin
      w_flat = '0;
      for (int unsigned i = 0; i < 16; i++)
         w_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_w[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_oc      <= '0;
         r_ic      <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
         r_fresh   <= 1'b0;
         r_held    <= 1'b0;
         r_done    <= 1'b0;
         r_data    <= '0;
         r_bias    <= '0;
         for (int unsigned i = 0; i < 16; i++)
            r_w[i] <= '0;
      end else begin
         r_done  <= 1'b0;
         r_fresh <= w_fbuf_rd;
         r_held  <= w_lv && !layer_ready;
         if (w_lv)
            r_data <= w_ldata;
         if (w_out_inc)
            r_out_cnt <= r_out_cnt + OUTC_W'(1);

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_oc    <= '0;
                  r_ic    <= '0;
                  r_cnt   <= '0;
                  r_state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_in_cnt  <= '0;
               r_out_cnt <= '0;
               if (r_cnt == 5'd1) begin
                  r_cnt   <= '0;
                  r_state <= S_LOAD_W;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            S_LOAD_W: begin
               // r_cnt-1 is the read whose data is on wrom_data this cycle
               if (r_cnt == 5'd17)
                  r_bias <= wrom_data;
               else if (r_cnt != 5'd0)
                  r_w[4'(r_cnt - 5'd1)] <= wrom_data;
               if (r_cnt == 5'd17) begin
                  r_cnt   <= '0;
                  r_state <= S_STREAM;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            S_STREAM: begin
               if (w_fbuf_rd)
                  r_in_cnt <= r_in_cnt + INC_W'(1);
               if ((r_in_cnt == INC_W'(PIX_IN)) && (!w_lv || layer_ready))
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (r_out_cnt == OUTC_W'(PIX_OUT))
                  r_state <= S_NEXT;
            end
            S_NEXT: begin
               if (r_ic == IC_W'(IN_CH - 1)) begin
                  r_ic <= '0;
                  r_oc <= (r_oc == OC_W'(OUT_CH - 1)) ? '0 : r_oc + OC_W'(1);
               end else begin
                  r_ic <= r_ic + IC_W'(1);
               end
               if (w_last_pass) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_CLEAR;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trans_conv_pass_scheduler.sv
// Directed bench for trans_conv_pass_scheduler: ROM/buffer models, a datapath strobe model and
// queue scoreboards for ROM addresses, buffer addresses, streamed words and per-pass tags.
module tb_trans_conv_pass_scheduler;

   localparam int PIX_IN  = 49;
   localparam int PIX_OUT = 196;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic          wrom_rd;
   logic [6:0]    wrom_addr;
   logic [15:0]   wrom_data = '0;
   logic          fbuf_rd;
   logic [6:0]    fbuf_addr;
   logic [15:0]   fbuf_data = '0;
   logic          layer_rst;
   logic          layer_valid;
   logic [15:0]   layer_data;
   logic          layer_ready;
   logic          layer_valid_out;
   logic [255:0]  w_flat;
   logic [15:0]   bias_out;
   logic [0:0]    oc_idx;
   logic [0:0]    ic_idx;
   logic          acc_first;
   logic          acc_last;

   trans_conv_pass_scheduler #(
      .IN_WIDTH(7), .DATA_WIDTH(16), .IN_CH(2), .OUT_CH(2),
      .PAD_TOP(1), .PAD_BOTTOM(2), .PAD_LEFT(1), .PAD_RIGHT(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .wrom_rd(wrom_rd), .wrom_addr(wrom_addr), .wrom_data(wrom_data),
      .fbuf_rd(fbuf_rd), .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data),
      .layer_rst(layer_rst), .layer_valid(layer_valid), .layer_data(layer_data),
      .layer_ready(layer_ready), .layer_valid_out(layer_valid_out),
      .w_flat(w_flat), .bias_out(bias_out), .oc_idx(oc_idx), .ic_idx(ic_idx),
      .acc_first(acc_first), .acc_last(acc_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] wrom_mem [66];
   logic [15:0] fbuf_mem [98];
   always @(posedge clk) if (wrom_rd) wrom_data <= wrom_mem[wrom_addr];
   always @(posedge clk) if (fbuf_rd) fbuf_data <= fbuf_mem[fbuf_addr];

   int            n_checks = 0;
   int            n_fail   = 0;
   int            done_cnt = 0;
   bit            bp_mode  = 1'b0;
   int            dp_delay = 0;
   int            dp_extra = 0;
   int            final_cyc = 0;
   int            final_seq = 0;
   int            seen_seq  = 0;

   int            exp_wa [$];
   int            exp_fa [$];
   logic [15:0]   exp_d  [$];
   logic [255:0]  exp_w  [$];
   logic [15:0]   exp_b  [$];
   int            exp_oc [$];
   int            exp_ic [$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_run();
      logic [255:0] w;
      for (int oc = 0; oc < 2; oc++) begin
         for (int ic = 0; ic < 2; ic++) begin
            w = '0;
            for (int k = 0; k < 16; k++) begin
               exp_wa.push_back((oc*2 + ic)*16 + k);
               w[k*16 +: 16] = wrom_mem[(oc*2 + ic)*16 + k];
            end
            exp_wa.push_back(64 + oc);
            exp_w.push_back(w);
            exp_b.push_back(wrom_mem[64 + oc]);
            exp_oc.push_back(oc);
            exp_ic.push_back(ic);
            for (int j = 0; j < PIX_IN; j++) begin
               exp_fa.push_back(ic*PIX_IN + j);
               exp_d.push_back(fbuf_mem[ic*PIX_IN + j]);
            end
         end
      end
   endtask

   task automatic flush();
      exp_wa.delete(); exp_fa.delete(); exp_d.delete();
      exp_w.delete();  exp_b.delete();  exp_oc.delete(); exp_ic.delete();
   endtask

   task automatic check_drained(input string tag);
      chk({tag, "_wrom_left"}, exp_wa.size(), 0);
      chk({tag, "_fbuf_left"}, exp_fa.size(), 0);
      chk({tag, "_data_left"}, exp_d.size(), 0);
      chk({tag, "_pass_left"}, exp_oc.size(), 0);
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int i = 0;
      while (done_cnt < target && i < budget) begin
         step();
         i++;
      end
      chk({tag, "_done_seen"}, done_cnt, target);
      repeat (5) step();
      chk({tag, "_single_done"}, done_cnt, target);
   endtask

   task automatic wait_stream(input string tag);
      int i = 0;
      while (!fbuf_rd && i < 200) begin
         step();
         i++;
      end
      chk({tag, "_stream_reached"}, fbuf_rd, 1);
   endtask

   task automatic drive_ready();
      forever begin
         @(posedge clk);
         #1;
         layer_ready = bp_mode ? ~layer_ready : 1'b1;
      end
   endtask

   // Datapath stand-in: after a pass's PIX_IN-th transfer, emits PIX_OUT strobes (the last one
   // optionally delayed) plus optional surplus strobes.
   task automatic emitter();
      int  n, k, gap;
      bit  abort;
      forever begin
         n = 0;
         while (n < PIX_IN) begin
            @(negedge clk);
            if (rst) n = 0;
            else if (layer_valid && layer_ready) n++;
         end
         k = 0; gap = 0; abort = 1'b0;
         while (k < PIX_OUT + dp_extra && !abort) begin
            @(negedge clk);
            if (rst) begin
               abort = 1'b1;
               layer_valid_out = 1'b0;
            end else if (k == PIX_OUT - 1 && gap < dp_delay) begin
               layer_valid_out = 1'b0;
               gap++;
            end else begin
               layer_valid_out = 1'b1;
               if (k == PIX_OUT - 1) begin
                  final_cyc = cyc;
                  final_seq++;
               end
               k++;
            end
         end
         if (!abort) @(negedge clk);
         layer_valid_out = 1'b0;
      end
   endtask

   task automatic monitor();
      int          rd_in_pass = 0;
      int          cur_oc = 0;
      int          cur_ic = 0;
      logic        prev_stall = 1'b0;
      logic [15:0] prev_data = '0;
      logic        prev_lrst = 1'b0;
      logic        prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rd_in_pass = 0;
            prev_stall = 1'b0;
            prev_lrst  = 1'b0;
            prev_done  = 1'b0;
            seen_seq   = final_seq;
         end else begin
            if (wrom_rd) begin
               chk("wrom_read_expected", exp_wa.size() != 0, 1);
               if (exp_wa.size() != 0) chk("wrom_addr", wrom_addr, exp_wa.pop_front());
            end
            if (fbuf_rd) begin
               chk("fbuf_read_expected", exp_fa.size() != 0, 1);
               if (exp_fa.size() != 0) chk("fbuf_addr", fbuf_addr, exp_fa.pop_front());
               if (rd_in_pass == 0 && exp_oc.size() != 0) begin
                  cur_oc = exp_oc.pop_front();
                  cur_ic = exp_ic.pop_front();
                  chk("oc_idx", oc_idx, cur_oc);
                  chk("ic_idx", ic_idx, cur_ic);
                  chk("acc_first", acc_first, cur_ic == 0);
                  chk("acc_last", acc_last, cur_ic == 1);
                  chk("w_flat", w_flat, exp_w.pop_front());
                  chk("bias_out", bias_out, exp_b.pop_front());
               end
               rd_in_pass = (rd_in_pass == PIX_IN - 1) ? 0 : rd_in_pass + 1;
            end
            if (prev_stall) begin
               chk("stall_valid_held", layer_valid, 1);
               chk("stall_data_held", layer_data, prev_data);
            end
            if (layer_valid && layer_ready) begin
               chk("xfer_expected", exp_d.size() != 0, 1);
               if (exp_d.size() != 0) chk("layer_data", layer_data, exp_d.pop_front());
               chk("oc_idx_stable", oc_idx, cur_oc);
               chk("acc_first_stable", acc_first, cur_ic == 0);
            end
            prev_stall = layer_valid && !layer_ready;
            prev_data  = layer_data;
            if (layer_rst && !prev_lrst && final_seq != seen_seq) begin
               chk("clear_after_last_strobe", cyc, final_cyc + 3);
               seen_seq = final_seq;
            end
            if (done) chk("done_one_cycle", prev_done, 0);
            if (done && !prev_done) begin
               chk("done_after_last_strobe", final_seq != seen_seq, 1);
               chk("done_timing", cyc, final_cyc + 3);
               chk("busy_low_with_done", busy, 0);
               seen_seq = final_seq;
               done_cnt++;
            end
            prev_lrst = layer_rst;
            prev_done = done;
         end
      end
   endtask

   initial begin
      int nrd;
      int run;
      rst = 1'b1;
      start = 1'b0;
      layer_ready = 1'b1;
      layer_valid_out = 1'b0;
      for (int i = 0; i < 66; i++) wrom_mem[i] = 16'($urandom);
      for (int i = 0; i < 98; i++) fbuf_mem[i] = 16'($urandom);
      fork
         monitor();
         emitter();
         drive_ready();
      join_none

      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_strobes", {wrom_rd, fbuf_rd, layer_valid, layer_rst}, 0);
      chk("rst_addrs", {wrom_addr, fbuf_addr}, 0);
      chk("rst_layer_data", layer_data, 0);
      chk("rst_w_flat", w_flat, 0);
      chk("rst_bias", bias_out, 0);
      chk("rst_tags", {oc_idx, ic_idx, acc_first, acc_last}, 0);

      // Run 1: ready held high, cycle-exact pass preamble
      push_run();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("c1_layer_rst", layer_rst, 1);
      chk("c1_busy", busy, 1);
      step();
      chk("c2_layer_rst", layer_rst, 1);
      chk("c2_wrom_rd", wrom_rd, 0);
      nrd = 0;
      for (int c = 3; c <= 20; c++) begin
         step();
         if (c == 3) chk("c3_wrom_rd", wrom_rd, 1);
         if (c == 3) chk("c3_layer_rst", layer_rst, 0);
         if (c == 20) chk("c20_wrom_rd", wrom_rd, 0);
         if (wrom_rd) nrd++;
      end
      chk("rom_read_count", nrd, 17);
      step();
      chk("c21_fbuf_rd", fbuf_rd, 1);
      chk("c21_layer_valid", layer_valid, 0);
      step();
      chk("c22_layer_valid", layer_valid, 1);
      run = 1;
      for (int c = 22; c < 90; c++) begin
         if (!fbuf_rd) break;
         run++;
         step();
      end
      chk("fbuf_rd_run_length", run, PIX_IN);
      wait_done("run1", 1, 3000);
      check_drained("run1");

      // Run 2: toggling ready, delayed final strobe, surplus strobes, start while busy
      bp_mode  = 1'b1;
      dp_delay = 50;
      dp_extra = 3;
      push_run();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_stream("run2");
      repeat (5) step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("run2_busy_after_restart_attempt", busy, 1);
      wait_done("run2", 2, 5000);
      check_drained("run2");
      bp_mode  = 1'b0;
      dp_delay = 0;
      dp_extra = 0;

      // Run 3: reset mid-stream, then a clean run from (0,0)
      push_run();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_stream("run3");
      repeat (10) step();
      rst = 1'b1;
      step();
      chk("midrst_busy", busy, 0);
      chk("midrst_strobes", {wrom_rd, fbuf_rd, layer_valid, layer_rst, done}, 0);
      chk("midrst_w_flat", w_flat, 0);
      chk("midrst_bias", bias_out, 0);
      chk("midrst_tags", {oc_idx, ic_idx, acc_first, acc_last}, 0);
      step();
      rst = 1'b0;
      chk("postrst_strobes", {wrom_rd, fbuf_rd, layer_valid, layer_rst, busy}, 0);
      flush();
      push_run();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("run3", 3, 3000);
      check_drained("run3");

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/trans_conv_pass_scheduler.md
# trans_conv_pass_scheduler

Sequencer that runs a transposed-convolution layer (upsample ×2 → zero-pad → 4×4 conv) over every (output-channel, input-channel) pair of a multi-channel feature map. For each pass it:
- clears the datapath,
- loads that pass's 16 kernel weights and the output-channel bias from weight ROM,
- streams one input channel from the feature buffer into the layer with valid/ready handshaking,
- waits until the layer has produced a full output plane.

It sits between the weight ROM / feature buffer and the single shared transposed-conv datapath. It also drives pass tags consumed by the downstream per-channel accumulator.

## Interface
Parameters:
- IN_WIDTH, 7, input plane side (square)
- DATA_WIDTH, 16, sample/weight width (signed)
- IN_CH, 2, input channels
- OUT_CH, 2, output channels
- PAD_TOP / PAD_BOTTOM / PAD_LEFT / PAD_RIGHT, 1 / 2 / 1 / 2, padding applied by the datapath
- Derived:
  - OUT_W = 2·IN_WIDTH+PAD_LEFT+PAD_RIGHT−3
  - OUT_H = 2·IN_WIDTH+PAD_TOP+PAD_BOTTOM−3
  - PIX_IN = IN_WIDTH²
  - PIX_OUT = OUT_W·OUT_H

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a full run; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pass.
- wrom_rd  out  1  weight ROM read strobe.
- wrom_addr  out  clog2(OUT_CH·IN_CH·16+OUT_CH)  weight ROM address.
- wrom_data  in  DATA_WIDTH  ROM data, valid 1 cycle after wrom_rd.
- fbuf_rd  out  1  feature buffer read strobe.
- fbuf_addr  out  clog2(IN_CH·PIX_IN)  feature buffer address.
- fbuf_data  in  DATA_WIDTH  buffer data, valid 1 cycle after fbuf_rd.
- layer_rst  out  1  active-high datapath clear; the integrator inverts it for an active-low datapath reset.
- layer_valid  out  1  sample valid to the datapath.
- layer_data  out  DATA_WIDTH  sample to the datapath.
- layer_ready  in  1  datapath backpressure.
- layer_valid_out  in  1  datapath output strobe; counted, not consumed.
- w_flat  out  16·DATA_WIDTH  kernel; w0 is at bits [DATA_WIDTH−1:0].
- bias_out  out  DATA_WIDTH  bias for the current pass.
- oc_idx, ic_idx  out  clog2 widths  current pass indices.
- acc_first  out  1  high during the pass when ic_idx==0.
- acc_last  out  1  high during the pass when ic_idx==IN_CH−1.

## Operation
States and transitions:
- IDLE: wait for start; on start, oc=ic=0 → CLEAR.
- CLEAR: 2 cycles; layer_rst=1, out_cnt=0, in_cnt=0 → LOAD_W.
- LOAD_W: 18 cycles.
  - Cycles k=0..15: read wrom_addr=(oc·IN_CH+ic)·16+k.
  - Cycle 16: read bias at OUT_CH·IN_CH·16+oc.
  - Data returning in cycle k+1 is captured into w[k] (k=16 → bias_out).
  - Then → STREAM.
- STREAM: issue input reads.
  - fbuf_rd = (in_cnt<PIX_IN) && (!layer_valid || layer_ready).
  - fbuf_addr = ic·PIX_IN+in_cnt; in_cnt increments on each read.
  - A read in cycle t loads layer_data and sets layer_valid at t+1.
  - layer_valid clears on transfer (layer_valid && layer_ready) when no new read returns that cycle.
  - Words held under backpressure stay stable.
  - When in_cnt==PIX_IN and the last word has transferred → DRAIN.
- DRAIN: wait for out_cnt==PIX_OUT → NEXT.
  - out_cnt increments on layer_valid_out in both STREAM and DRAIN.
  - Output strobes beyond PIX_OUT are ignored; no counter wrap.
- NEXT: 1 cycle.
  - ic increments; on ic wrap to 0, oc increments.
  - If the pass just finished was (OUT_CH−1, IN_CH−1): done=1 → IDLE. Otherwise → CLEAR.

Other rules:
- w_flat and bias_out hold their values from the end of LOAD_W through DRAIN.
- start while busy is ignored.
- rst in any state → IDLE next cycle, with all counters and outputs zero. No partial pass resumes.

## Timing
- Reset values: all outputs 0, including w_flat, bias_out, indices, acc_first and acc_last.
- start sampled at cycle 0 gives:
  - CLEAR in cycles 1–2 (layer_rst=1)
  - LOAD_W in cycles 3–20 (wrom_rd in cycles 3–19)
  - first fbuf_rd in cycle 21, first layer_valid in cycle 22
- With layer_ready held high, fbuf_rd is high for PIX_IN consecutive cycles (cycles 21..21+PIX_IN−1).
- done rises exactly 1 cycle after the DRAIN→NEXT transition of the final pass and lasts 1 cycle. busy falls in the same cycle done is high.
- acc_first, acc_last, oc_idx and ic_idx are stable for the whole pass, from CLEAR through NEXT.

## Test plan
- Reset: assert rst for 2 cycles mid-run → all outputs 0, busy=0, and no strobe in the cycle after rst.
- Single pass, defaults, ready=1, with a datapath model emitting 196 valid_out strobes → wrom_addr sequence 0..15 then 64; 49 fbuf reads at addresses 0..48; done at the end of the 4th pass only; layer_data order equals buffer order.
- Backpressure: layer_ready toggles 1,0,1,0 → exactly 49 transfers with no duplicates or drops, and layer_data held stable while ready=0.
- Full run: passes observed as (oc,ic) = (0,0),(0,1),(1,0),(1,1); fbuf base addresses 0,49,0,49; ROM bases 0,16,32,48; acc_first high only on ic=0 passes; exactly one done pulse.
- Drain gating: the datapath model delays its final valid_out by 50 cycles → state stays DRAIN and there is no CLEAR until the 196th strobe; extra strobes are ignored.
- Start while busy: pulse start during STREAM → no restart and pass order unchanged. Reset mid-STREAM followed by start → run restarts at (0,0) with wrom_addr=0.
